alu_sequencer: RTL and testbench
================================

# alu_sequencer

Parametrised successor to the fixed 8-bit PC/ROM/ALU-mux datapath. The block holds a writable op-code program store (DEPTH entries) and steps through it with a program counter. For each op it accepts operands over a valid/ready handshake, executes the op (single-cycle, or iterative for divide) and presents the result and flags over a second valid/ready handshake. It sits between an operand source (bench or host FSM) and a result consumer.

## Interface
- WIDTH, 8, datapath width in bits (≥4)
- DEPTH, 16, program store entries (power of two, ≥2); AW = clog2(DEPTH) is a localparam
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; one clock domain only
- start  in  1  pulse; starts execution at address 0 when IDLE or HALTED, ignored otherwise
- prog_we  in  1  program write strobe; honoured only when busy=0
- prog_addr  in  AW  program write address
- prog_op  in  4  op-code written
- in_valid  in  1  operands valid
- in_ready  out  1  high only in WAIT_OP
- a, b  in  WIDTH each  operands
- cin  in  1  carry/borrow in for ADD/SUB
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  registered result
- flags  out  5  {E,V,C,N,Z}, registered
- pc  out  AW  current program address
- op_out  out  4  op-code currently held
- busy  out  1  high in every state except IDLE and HALTED

## Operation
- Op-codes:
  - 0 ADD: a+b+cin
  - 1 SUB: a−b−cin
  - 2 MUL: low WIDTH bits of a*b
  - 3 DIV: unsigned a/b
  - 4 NOT a
  - 5 OR
  - 6 AND
  - 7 XOR
  - 8 LSL
  - 9 LSR
  - 10 ASR
  - 11 ROL
  - 12 ROR
  - 13 PASS a
  - 14 HALT
  - 15 JUMP
- Shifts and rotates use b as the amount. LSL and LSR with b≥WIDTH give 0. ASR with b≥WIDTH gives sign fill. Rotates use b mod WIDTH.
- Flags, written only on result-producing ops:
  - Z = (s==0); N = s[WIDTH-1].
  - C (ADD): carry out. C (SUB): borrow, i.e. a < b+cin unsigned. C (LSL/LSR/ASR): last bit shifted out, 0 if amount is 0. C: 0 for all other ops.
  - V (ADD/SUB): signed overflow. V (MUL): upper half of the 2·WIDTH product is nonzero. V: 0 otherwise.
  - E: 1 only for DIV with b==0.
- DIV with b==0 gives s = all ones and E=1, with no iteration.
- States:
  - IDLE: start → FETCH, pc=0.
  - FETCH: 1 cycle. Latch op_out = mem[pc]. If HALT → HALTED; else → WAIT_OP.
  - WAIT_OP: in_ready=1. When in_valid is high, capture a, b, cin. JUMP → pc=b[AW-1:0], then FETCH, with no output. DIV with b≠0 → DIV. Everything else → EXEC.
  - EXEC: 1 cycle. Register s and flags → OUT.
  - DIV: restoring divider, one quotient bit per cycle, exactly WIDTH cycles → OUT.
  - OUT: out_valid=1. s and flags are held stable until out_ready. On the handshake: pc = pc+1 (DEPTH−1 wraps to 0) → FETCH.
  - HALTED: pc and op_out hold. start → FETCH, pc=0.
- Program store:
  - Writes take effect on the clock edge.
  - A write together with start in IDLE is visible to the following FETCH.
  - prog_we while busy=1 is dropped.
- Reset, asynchronous and effective immediately:
  - Controller goes to IDLE.
  - pc, s, flags, op_out, out_valid, in_ready and busy go to 0.
  - Every program entry goes to HALT (4'hE).
  - An operation in progress is abandoned and no result is emitted.

## Timing
- Let k be the cycle in which in_valid & in_ready.
- Non-DIV ops, and DIV with b==0: out_valid is high from cycle k+2.
- DIV with b≠0: out_valid is high from cycle k+WIDTH+1.
- With out_ready held high, the next FETCH occurs the cycle after OUT, and in_ready reasserts 2 cycles after the output handshake.
- JUMP: FETCH of the target occurs in cycle k+1.
- start → first in_ready: 2 cycles (start sampled, then FETCH, then WAIT_OP).
- Single-issue: there is never more than one op in flight, and in_ready=0 whenever out_valid=1.

## Test plan
1. Program [ADD, HALT], start, a=7F, b=06, cin=0 → s=85, flags V=1, N=1, C=0, Z=0, E=0. Then HALTED with pc=1 and busy=0.
2. Program [ADD, SUB, HALT]:
   - ADD with a=FF, b=01 → s=00, Z=1, C=1, V=0.
   - SUB with a=00, b=01 → s=FF, C=1, N=1.
3. Program [DIV, DIV, HALT]:
   - a=64, b=07 → s=0E, with out_valid first high exactly at k+9.
   - a=3B, b=00 → s=FF, E=1, with out_valid at k+2.
4. Program [MUL, ROL, LSR]:
   - MUL with a=11, b=10 → s=10, V=1.
   - ROL with a=55, b=09 → s=AA.
   - LSR with a=AA, b=03 → s=15, C=0.
5. Program with JUMP at 0, ADD at address 15, HALT at 0 after a rewrite:
   - JUMP with b=0F → pc=15.
   - ADD → after the handshake pc wraps to 0.
   - Holding out_ready=0 for 5 cycles keeps s, flags and pc stable and in_ready=0.
6. Assert reset in the 4th DIV iteration → all outputs 0 immediately. A subsequent start halts at pc=0, because the store was cleared to HALT. A prog_we issued while busy leaves the store unchanged.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps a writable op-code store with a program counter; each op takes
// operands over a valid/ready handshake, runs on a single-cycle ALU or an iterative
// restoring divider, and returns result and flags {E,V,C,N,Z} over a second handshake.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, waiting for start
// FETCH    | latch op_out from the store at pc, HALT ends the run
// WAIT_OP  | in_ready high, capture a/b/cin on in_valid
// EXEC     | register ALU result and flags
// DIV      | one quotient bit per cycle, WIDTH cycles
// OUT      | out_valid high, result held until out_ready
// HALTED   | HALT fetched, pc/op_out held, waiting for start
module alu_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [3:0]               prog_op,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         s,
    output logic [4:0]               flags,
    output logic [$clog2(DEPTH)-1:0] pc,
    output logic [3:0]               op_out,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_LSL  = 4'd8;
    localparam logic [3:0] OP_LSR  = 4'd9;
    localparam logic [3:0] OP_ASR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_ROR  = 4'd12;
    localparam logic [3:0] OP_PASS = 4'd13;
    localparam logic [3:0] OP_HALT = 4'd14;
    localparam logic [3:0] OP_JUMP = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_OP,
        ST_EXEC,
        ST_DIV,
        ST_OUT,
        ST_HALTED
    } state_t;

    state_t           state;
    logic [3:0]       mem [0:DEPTH-1];
    logic [WIDTH-1:0] a_r, b_r;
    logic             cin_r;
    logic [WIDTH-1:0] div_rem, div_quot;
    logic [CW-1:0]    div_cnt;

    logic [WIDTH:0]     add_t, sub_t, lsl_t, lsr_t, asr_t;
    logic [2*WIDTH-1:0] mul_t;
    logic [WIDTH-1:0]   rot_amt, rol_t, ror_t;
    logic [WIDTH-1:0]   alu_s;
    logic               alu_c, alu_v, alu_e;
    logic [4:0]         alu_f;

    logic [WIDTH:0]   div_trial, div_diff;
    logic [WIDTH-1:0] div_rem_next, div_quot_next;

    // Program store: cleared to HALT on reset, writable only while not busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= OP_HALT;
        end else if (prog_we && !busy) begin
            mem[prog_addr] <= prog_op;
        end
    end

    // Single-cycle ALU on the captured operands; shifts carry the last bit out in the extra bit.
    always_comb begin
        add_t   = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
        sub_t   = {1'b0, a_r} - {1'b0, b_r} - {{WIDTH{1'b0}}, cin_r};
        mul_t   = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
        lsl_t   = {1'b0, a_r} << b_r;
        lsr_t   = {a_r, 1'b0} >> b_r;
        asr_t   = $signed({a_r, 1'b0}) >>> b_r;
        rot_amt = b_r % WIDTH_V;
        rol_t   = (a_r << rot_amt) | (a_r >> (WIDTH_V - rot_amt));
        ror_t   = (a_r >> rot_amt) | (a_r << (WIDTH_V - rot_amt));
        alu_s   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (op_out)
            OP_ADD: begin
                alu_s = add_t[WIDTH-1:0];
                alu_c = add_t[WIDTH];
                alu_v = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_t[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_SUB: begin
                alu_s = sub_t[WIDTH-1:0];
                alu_c = sub_t[WIDTH];
                alu_v = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (sub_t[WIDTH-1] != a_r[WIDTH-1]);
            end
            OP_MUL: begin
                alu_s = mul_t[WIDTH-1:0];
                alu_v = |mul_t[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                // Only reaches EXEC with a zero divisor.
                alu_s = '1;
                alu_e = 1'b1;
            end
            OP_NOT:  alu_s = ~a_r;
            OP_OR:   alu_s = a_r | b_r;
            OP_AND:  alu_s = a_r & b_r;
            OP_XOR:  alu_s = a_r ^ b_r;
            OP_LSL: begin
                alu_s = lsl_t[WIDTH-1:0];
                alu_c = lsl_t[WIDTH];
            end
            OP_LSR: begin
                alu_s = lsr_t[WIDTH:1];
                alu_c = lsr_t[0];
            end
            OP_ASR: begin
                alu_s = asr_t[WIDTH:1];
                alu_c = asr_t[0];
            end
            OP_ROL:  alu_s = rol_t;
            OP_ROR:  alu_s = ror_t;
            OP_PASS: alu_s = a_r;
            default: alu_s = '0;
        endcase
        alu_f = {alu_e, alu_v, alu_c, alu_s[WIDTH-1], (alu_s == '0)};
    end

    // One restoring-division step: dividend bits enter from the top of div_quot.
    always_comb begin
        div_trial = {div_rem, div_quot[WIDTH-1]};
        div_diff  = div_trial - {1'b0, b_r};
        if (!div_diff[WIDTH]) begin
            div_rem_next  = div_diff[WIDTH-1:0];
            div_quot_next = {div_quot[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_next  = div_trial[WIDTH-1:0];
            div_quot_next = {div_quot[WIDTH-2:0], 1'b0};
        end
    end

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= '0;
            op_out    <= '0;
            s         <= '0;
            flags     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            cin_r     <= 1'b0;
            div_rem   <= '0;
            div_quot  <= '0;
            div_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    op_out <= mem[pc];
                    if (mem[pc] == OP_HALT) begin
                        busy  <= 1'b0;
                        state <= ST_HALTED;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= ST_WAIT_OP;
                    end
                end
                ST_WAIT_OP: begin
                    if (in_valid) begin
                        a_r      <= a;
                        b_r      <= b;
                        cin_r    <= cin;
                        in_ready <= 1'b0;
                        if (op_out == OP_JUMP) begin
                            pc    <= b[AW-1:0];
                            state <= ST_FETCH;
                        end else if (op_out == OP_DIV && b != '0) begin
                            div_rem  <= '0;
                            div_quot <= a;
                            div_cnt  <= CW'(WIDTH - 1);
                            state    <= ST_DIV;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    s         <= alu_s;
                    flags     <= alu_f;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
                end
                ST_DIV: begin
                    div_rem  <= div_rem_next;
                    div_quot <= div_quot_next;
                    if (div_cnt == '0) begin
                        s         <= div_quot_next;
                        flags     <= {3'b000, div_quot_next[WIDTH-1], (div_quot_next == '0)};
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pc        <= pc + 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                default: begin
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed program scenarios plus a randomized program run,
// checked against an arithmetic reference model and a walk of the program store.
module tb_alu_sequencer;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [3:0]    prog_op = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  s;
    logic [4:0]    flags;
    logic [AW-1:0] pc;
    logic [3:0]    op_out;
    logic          busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [3:0]    prog_m [D];
    logic [AW-1:0] pc_m = '0;
    logic          exp_armed = 1'b0;
    logic [W-1:0]  exp_s = '0;
    logic [4:0]    exp_f = '0;
    logic [AW-1:0] exp_pc = '0;

    alu_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_op(prog_op), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .flags(flags), .pc(pc), .op_out(op_out),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, expv);
    endtask

    // Reference arithmetic: plain integer maths on the operand values.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a8, input logic [W-1:0] b8,
                         input logic c1, output logic [W-1:0] rs, output logic [4:0] rf);
        longint av, bv, cv, m, r, sa, sb, t;
        bit c, v, e;
        av = longint'(a8); bv = longint'(b8); cv = longint'(c1);
        m = 255; r = 0; c = 0; v = 0; e = 0;
        sa = (av > 127) ? av - 256 : av;
        sb = (bv > 127) ? bv - 256 : bv;
        case (op)
            0: begin t = av + bv + cv; r = t & m; c = t > m; t = sa + sb + cv; v = (t > 127) || (t < -128); end
            1: begin t = av - bv - cv; r = t & m; c = av < bv + cv; t = sa - sb - cv; v = (t > 127) || (t < -128); end
            2: begin t = av * bv; r = t & m; v = t > m; end
            3: begin if (bv == 0) begin r = m; e = 1; end else r = av / bv; end
            4: r = (~av) & m;
            5: r = av | bv;
            6: r = av & bv;
            7: r = av ^ bv;
            8: begin r = (bv >= W) ? 0 : ((av << bv) & m); c = (bv >= 1 && bv <= W) ? (((av >> (W - bv)) & 1) != 0) : 0; end
            9: begin r = (bv >= W) ? 0 : (av >> bv); c = (bv >= 1 && bv <= W) ? (((av >> (bv - 1)) & 1) != 0) : 0; end
            10: begin
                r = (bv >= W) ? ((sa < 0) ? m : 0) : ((sa >>> bv) & m);
                c = (bv == 0) ? 0 : (bv <= W) ? (((av >> (bv - 1)) & 1) != 0) : (sa < 0);
            end
            11: begin r = av; repeat (bv % W) r = ((r << 1) | (r >> (W - 1))) & m; end
            12: begin r = av; repeat (bv % W) r = ((r >> 1) | ((r & 1) << (W - 1))) & m; end
            13: r = av;
            default: r = 0;
        endcase
        rs = r[W-1:0];
        rf = {e, v, c, r[W-1], (r == 0)};
    endtask

    // Every cycle a result is presented it must match the model and stay put.
    always @(negedge clk) begin
        if (!reset && out_valid)
            chk("out_hold", 32'({exp_armed, s, flags, pc, in_ready, busy}),
                32'({1'b1, exp_s, exp_f, exp_pc, 1'b0, 1'b1}));
    end

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; start = 1'b0; prog_we = 1'b0;
        exp_armed = 1'b0;
        #1;
        chk("reset_outs", 32'({pc, s, flags, op_out, out_valid, in_ready, busy}), 32'(0));
        for (int i = 0; i < D; i++) prog_m[i] = 4'hE;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_prog(input logic [AW-1:0] wa, input logic [3:0] wo);
        prog_we = 1'b1; prog_addr = wa; prog_op = wo; prog_m[wa] = wo;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Two cycles after the FETCH the model's next op decides: halted or ready.
    task automatic check_next();
        if (prog_m[pc_m] == 4'hE) chk("halted", 32'({busy, pc, op_out}), 32'({1'b0, pc_m, 4'hE}));
        else chk("in_ready_back", 32'({in_ready, busy}), 32'({1'b1, 1'b1}));
    endtask

    task automatic pulse_start(input bit we, input logic [AW-1:0] wa, input logic [3:0] wo);
        start = 1'b1;
        if (we) begin prog_we = 1'b1; prog_addr = wa; prog_op = wo; prog_m[wa] = wo; end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        chk("start_fetch", 32'({busy, in_ready, out_valid}), 32'({1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        pc_m = '0;
        check_next();
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                          input int hold, output logic [W-1:0] gs, output logic [4:0] gf);
        logic [3:0]   op;
        logic [W-1:0] ms;
        logic [4:0]   mf;
        int n;
        gs = '0; gf = '0;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin chk("in_ready_timeout", 32'(in_ready), 32'(1)); return; end
        op = prog_m[pc_m];
        chk("fetch_pc_op", 32'({pc, op_out}), 32'({pc_m, op}));
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        if (op != 4'hF) begin
            model(op, ta, tb, tc, ms, mf);
            exp_s = ms; exp_f = mf; exp_pc = pc_m; exp_armed = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (op == 4'hF) begin
            pc_m = tb[AW-1:0];
            chk("jump_pc", 32'({pc, in_ready, out_valid}), 32'({pc_m, 1'b0, 1'b0}));
        end else begin
            n = 1;
            while (!out_valid && n < 3 * W) begin @(negedge clk); n++; end
            chk("latency", 32'(n), 32'((op == 4'd3 && tb != 0) ? W + 1 : 2));
            gs = s; gf = flags;
            repeat (hold) @(negedge clk);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0; exp_armed = 1'b0;
            pc_m = pc_m + 1'b1;
            chk("after_out", 32'({pc, out_valid, in_ready}), 32'({pc_m, 1'b0, 1'b0}));
        end
        @(negedge clk);
        check_next();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] gs, ms;
        logic [4:0]   gf, mf;
        logic [3:0]   rop;

        // Literal pins on the reference model itself.
        model(4'd0, 8'h7F, 8'h06, 1'b0, ms, mf);
        chk("pin_add", 32'({ms, mf}), 32'({8'h85, 5'b01010}));
        model(4'd10, 8'h80, 8'd9, 1'b0, ms, mf);
        chk("pin_asr", 32'({ms, mf}), 32'({8'hFF, 5'b00110}));
        model(4'd8, 8'h81, 8'd1, 1'b0, ms, mf);
        chk("pin_lsl", 32'({ms, mf}), 32'({8'h02, 5'b00100}));

        // Test 1: write coinciding with start, ADD overflow, halt at pc=1.
        do_reset();
        pulse_start(1'b1, 4'd0, 4'd0);
        run_op(8'h7F, 8'h06, 1'b0, 0, gs, gf);
        chk("t1_add", 32'({gs, gf}), 32'({8'h85, 5'b01010}));
        chk("t1_halt", 32'({pc, busy}), 32'({4'd1, 1'b0}));

        // Test 2: ADD carry/zero, SUB borrow.
        write_prog(4'd0, 4'd0); write_prog(4'd1, 4'd1); write_prog(4'd2, 4'hE);
        pulse_start(1'b0, 4'd0, 4'd0);
        run_op(8'hFF, 8'h01, 1'b0, 1, gs, gf);
        chk("t2_add", 32'({gs, gf}), 32'({8'h00, 5'b00101}));
        run_op(8'h00, 8'h01, 1'b0, 0, gs, gf);
        chk("t2_sub", 32'({gs, gf}), 32'({8'hFF, 5'b00110}));

        // Test 3: iterative divide and divide by zero.
        write_prog(4'd0, 4'd3); write_prog(4'd1, 4'd3);
        pulse_start(1'b0, 4'd0, 4'd0);
        run_op(8'h64, 8'h07, 1'b0, 0, gs, gf);
        chk("t3_div", 32'({gs, gf}), 32'({8'h0E, 5'b00000}));
        run_op(8'h3B, 8'h00, 1'b0, 2, gs, gf);
        chk("t3_div0", 32'({gs, gf}), 32'({8'hFF, 5'b10010}));

        // Test 4: MUL overflow, rotate mod width, logical right shift.
        write_prog(4'd0, 4'd2); write_prog(4'd1, 4'd11); write_prog(4'd2, 4'd9);
        pulse_start(1'b0, 4'd0, 4'd0);
        run_op(8'h11, 8'h10, 1'b0, 0, gs, gf);
        chk("t4_mul", 32'({gs, gf}), 32'({8'h10, 5'b01000}));
        run_op(8'h55, 8'h09, 1'b0, 0, gs, gf);
        chk("t4_rol", 32'({gs, gf}), 32'({8'hAA, 5'b00010}));
        run_op(8'hAA, 8'h03, 1'b0, 0, gs, gf);
        chk("t4_lsr", 32'({gs, gf}), 32'({8'h15, 5'b00000}));

        // Test 5: JUMP to the last entry, pc wrap, held output, dropped busy write.
        write_prog(4'd0, 4'hF); write_prog(4'd15, 4'd0);
        pulse_start(1'b0, 4'd0, 4'd0);
        run_op(8'h00, 8'h0F, 1'b0, 0, gs, gf);
        chk("t5_jump", 32'(pc), 32'(15));
        run_op(8'h12, 8'h34, 1'b1, 5, gs, gf);
        chk("t5_add", 32'({gs, gf, pc}), 32'({8'h47, 5'b00000, 4'd0}));
        prog_we = 1'b1; prog_addr = 4'd3; prog_op = 4'd0;
        @(negedge clk);
        prog_we = 1'b0;
        run_op(8'h00, 8'h03, 1'b0, 0, gs, gf);
        write_prog(4'd0, 4'hE);
        pulse_start(1'b0, 4'd0, 4'd0);

        // Test 6: reset in the 4th divide iteration, then a start halts at pc=0.
        write_prog(4'd0, 4'd3);
        pulse_start(1'b0, 4'd0, 4'd0);
        a = 8'h64; b = 8'h07; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_div_running", 32'({busy, out_valid, in_ready}), 32'({1'b1, 1'b0, 1'b0}));
        do_reset();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b1; prog_addr = 4'd0; prog_op = 4'd0;
        @(negedge clk);
        prog_we = 1'b0;
        pc_m = '0;
        check_next();
        pulse_start(1'b0, 4'd0, 4'd0);

        // Randomized program: no HALT, occasional JUMP, random operands and holds.
        do_reset();
        for (int i = 0; i < D; i++) begin
            rop = ($urandom % 8 == 0) ? 4'hF : 4'($urandom_range(0, 13));
            write_prog(AW'(i), rop);
        end
        pulse_start(1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 80; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = ($urandom % 3 == 0) ? W'($urandom_range(0, 10)) : W'($urandom);
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)), gs, gf);
        end
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
